// File: rtl/tsc_memory_responder.sv
// Fixed-latency 16-bit word memory responder on a shared tristate data bus.
// Optional build macro TSC_MEM_ACCESS_COUNT_EN adds read_count/write_count access counters.
module tsc_memory_responder #(
  parameter int LATENCY   = 2,
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        readM,
  input  logic        writeM,
  input  logic [15:0] address,
  inout  wire  [15:0] data,
  output logic        inputReady
`ifdef TSC_MEM_ACCESS_COUNT_EN
  ,
  output logic [15:0] read_count,
  output logic [15:0] write_count
`endif
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [15:0]            mem_q [DEPTH];
  logic                   wr_en_s;
  logic                   drive_s;
  logic                   unused_addr_s;

  // Writes are gated by reset_n so nothing commits while the block is held in reset.
  assign wr_en_s       = writeM & reset_n;
  assign unused_addr_s = ^address[15:ADDR_BITS];

  // Read FSM next-state: accept in IDLE, count down in WAIT, one-cycle RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (readM && !writeM) begin
          addr_d = address[ADDR_BITS-1:0];
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, latency counter and captured read address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Storage array; intentionally never cleared so contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[address[ADDR_BITS-1:0]] <= data;
    end
  end

  // Read data is fetched in RESP itself so writes landing during WAIT are visible.
  assign inputReady = (state_q == RESP);
  assign drive_s    = (state_q == RESP) && !writeM;
  assign data       = drive_s ? mem_q[addr_q] : 16'hzzzz;

`ifdef TSC_MEM_ACCESS_COUNT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  // Access counters wrap naturally at 16 bits.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (state_q == RESP) begin
      rd_cnt_d = rd_cnt_q + 16'd1;
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
    if (writeM) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_tsc_memory_responder.sv
// Directed bench for tsc_memory_responder: one LATENCY=2 and one LATENCY=4 instance.
// The data buses are pulled up, so an undriven (high-impedance) bus reads 16'hFFFF.
module tb_tsc_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_m   [2];
  logic        wr_m   [2];
  logic [15:0] addr   [2];
  logic        drv_en [2];
  logic [15:0] drv_v  [2];
  tri1  [15:0] bus0;
  tri1  [15:0] bus1;
  logic        ir0, ir1;
  int          n_chk = 0;
  int          n_err = 0;

  assign bus0 = drv_en[0] ? drv_v[0] : 16'hzzzz;
  assign bus1 = drv_en[1] ? drv_v[1] : 16'hzzzz;

  always #5 clk = ~clk;

`ifdef TSC_MEM_ACCESS_COUNT_EN
  logic [15:0] rc0, wc0, rc1, wc1;
`endif

  tsc_memory_responder #(.LATENCY(2), .ADDR_BITS(8)) u_l2 (
    .clk(clk), .reset_n(rst_n), .readM(rd_m[0]), .writeM(wr_m[0]),
    .address(addr[0]), .data(bus0), .inputReady(ir0)
`ifdef TSC_MEM_ACCESS_COUNT_EN
    , .read_count(rc0), .write_count(wc0)
`endif
  );

  tsc_memory_responder #(.LATENCY(4), .ADDR_BITS(8)) u_l4 (
    .clk(clk), .reset_n(rst_n), .readM(rd_m[1]), .writeM(wr_m[1]),
    .address(addr[1]), .data(bus1), .inputReady(ir1)
`ifdef TSC_MEM_ACCESS_COUNT_EN
    , .read_count(rc1), .write_count(wc1)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp_v);
    n_chk++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp_v, $time);
    end
  endtask

  function automatic logic [15:0] obs_ir(input int sel);
    return {15'd0, (sel == 0) ? ir0 : ir1};
  endfunction

  function automatic logic [15:0] obs_bus(input int sel);
    return (sel == 0) ? bus0 : bus1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int sel, input logic [15:0] a, input logic [15:0] v);
    rd_m[sel]   = 1'b0;
    wr_m[sel]   = 1'b1;
    addr[sel]   = a;
    drv_en[sel] = 1'b1;
    drv_v[sel]  = v;
    @(negedge clk);
    chk("wr_no_ready", obs_ir(sel), 16'd0);
    tick();
    wr_m[sel]   = 1'b0;
    drv_en[sel] = 1'b0;
  endtask

  // Read transaction; optional write in cycle wr_cyc (>0); jitter drops readM and scrambles address after acceptance.
  task automatic do_read(input int sel, input logic [15:0] a, input logic [15:0] exp_v,
                         input int wr_cyc, input logic [15:0] wa, input logic [15:0] wv,
                         input bit jitter);
    int lat;
    lat = (sel == 0) ? 2 : 4;
    for (int c = 0; c <= lat + 1; c++) begin
      rd_m[sel]   = (c == 0) || (!jitter && c <= lat);
      addr[sel]   = (c == 0 || !jitter) ? a : ~a;
      wr_m[sel]   = (c == wr_cyc) && (c > 0);
      drv_en[sel] = wr_m[sel];
      if (wr_m[sel]) begin
        addr[sel]  = wa;
        drv_v[sel] = wv;
      end
      @(negedge clk);
      if (c == lat) begin
        chk("rd_ready", obs_ir(sel), 16'd1);
        chk("rd_data", obs_bus(sel), wr_m[sel] ? wv : exp_v);
      end else begin
        chk("rd_not_ready", obs_ir(sel), 16'd0);
        if (!wr_m[sel]) chk("rd_bus_z", obs_bus(sel), 16'hFFFF);
      end
      tick();
    end
    rd_m[sel]   = 1'b0;
    wr_m[sel]   = 1'b0;
    drv_en[sel] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd_m[i] = 1'b0; wr_m[i] = 1'b0; addr[i] = 16'd0; drv_en[i] = 1'b0; drv_v[i] = 16'd0;
    end
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready0", obs_ir(0), 16'd0);
    chk("rst_ready1", obs_ir(1), 16'd0);
    chk("rst_bus0_z", bus0, 16'hFFFF);
    chk("rst_bus1_z", bus1, 16'hFFFF);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic read with Z checks around the response cycle.
    do_write(0, 16'd5, 16'h1234);
    do_read(0, 16'd5, 16'h1234, 0, 16'd0, 16'd0, 1'b0);

    // Upper address bits ignored; readM/address wiggle after acceptance ignored.
    do_write(0, 16'h0107, 16'hBEEF);
    do_read(0, 16'h0007, 16'hBEEF, 0, 16'd0, 16'd0, 1'b1);
    do_read(0, 16'hFF07, 16'hBEEF, 0, 16'd0, 16'd0, 1'b0);

    // Simultaneous read+write: write only, read accepted on the next writeM=0 cycle.
    rd_m[0] = 1'b1; wr_m[0] = 1'b1; addr[0] = 16'd3; drv_en[0] = 1'b1; drv_v[0] = 16'h00AA;
    @(negedge clk);
    chk("simul_no_ready", obs_ir(0), 16'd0);
    tick();
    wr_m[0] = 1'b0; drv_en[0] = 1'b0;
    do_read(0, 16'd3, 16'h00AA, 0, 16'd0, 16'd0, 1'b0);

    // LATENCY=4: write to the captured address in the second WAIT cycle.
    do_write(1, 16'd9, 16'h0001);
    do_read(1, 16'd9, 16'h0002, 2, 16'd9, 16'h0002, 1'b0);
    do_read(1, 16'd9, 16'h0002, 0, 16'd0, 16'd0, 1'b1);

    // Write during RESP: data left to the writer, inputReady still pulses, write commits.
    do_write(0, 16'h0020, 16'h1111);
    do_read(0, 16'h0020, 16'h1111, 2, 16'h0021, 16'h2222, 1'b0);
    do_read(0, 16'h0021, 16'h2222, 0, 16'd0, 16'd0, 1'b0);

    // readM held through RESP starts a second read in the following IDLE cycle.
    rd_m[0] = 1'b1; addr[0] = 16'd5;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("b2b_ready", obs_ir(0), (c == 2 || c == 5) ? 16'd1 : 16'd0);
      if (c == 2 || c == 5) chk("b2b_data", bus0, 16'h1234);
      tick();
    end
    rd_m[0] = 1'b0;
    tick();

    // Reset during WAIT: read abandoned, write under reset blocked, memory kept.
    rd_m[0] = 1'b1; addr[0] = 16'd5;
    tick();
    rd_m[0] = 1'b0; rst_n = 1'b0;
    wr_m[0] = 1'b1; drv_en[0] = 1'b1; drv_v[0] = 16'hDEAD;
    @(negedge clk);
    chk("rstmid_ready", obs_ir(0), 16'd0);
    tick();
    rst_n = 1'b1; wr_m[0] = 1'b0; drv_en[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rstmid_quiet", obs_ir(0), 16'd0);
      chk("rstmid_bus_z", bus0, 16'hFFFF);
      tick();
    end
    do_read(0, 16'd5, 16'h1234, 0, 16'd0, 16'd0, 1'b0);

`ifdef TSC_MEM_ACCESS_COUNT_EN
    rst_n = 1'b0;
    @(negedge clk);
    chk("cnt_rd_rst", rc0, 16'd0);
    chk("cnt_wr_rst", wc0, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_write(0, 16'h0040, 16'h0040);
    do_write(0, 16'h0041, 16'h0041);
    do_read(0, 16'h0040, 16'h0040, 0, 16'd0, 16'd0, 1'b0);
    do_read(0, 16'h0041, 16'h0041, 0, 16'd0, 16'd0, 1'b0);
    do_read(0, 16'h0005, 16'h1234, 0, 16'd0, 16'd0, 1'b0);
    @(negedge clk);
    chk("cnt_rd", rc0, 16'd3);
    chk("cnt_wr", wc0, 16'd2);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("cnt_rd_clr", rc0, 16'd0);
    chk("cnt_wr_clr", wc0, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tsc_memory_responder.md
TSC_MEMORY_RESPONDER -- requirements
Module: tsc_memory_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, meaning cycles from read acceptance to the inputReady cycle (legal range 1..15).
REQ-002 The block SHALL have parameter ADDR_BITS, default 8, meaning log2 of the word depth of the internal 16-bit storage array.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port readM, input, 1, read request, held high by the requester until inputReady.
REQ-006 The block SHALL have port writeM, input, 1, write request, valid for one cycle per store.
REQ-007 The block SHALL have port address, input, 16, word address; only bits [ADDR_BITS-1:0] are used.
REQ-008 The block SHALL have port data, inout, 16, shared data bus; requester drives it during writes, block drives it only during the response cycle.
REQ-009 The block SHALL have port inputReady, output, 1, one-cycle pulse marking valid read data on data.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-011 In IDLE with readM=1 and writeM=0, the block SHALL capture address[ADDR_BITS-1:0] at the rising edge.
- REQ-011 transition: to RESP if LATENCY=1, else to WAIT with counter loaded to LATENCY-2.
REQ-012 In WAIT the counter SHALL decrement each cycle; at 0 the FSM SHALL move to RESP.
- REQ-012 consequence: inputReady is high exactly LATENCY cycles after the acceptance cycle.
REQ-013 In RESP, inputReady SHALL be 1 for exactly one cycle, decoded from the state register.
- REQ-013 data: data = mem[captured address]; the next state is IDLE unconditionally.
REQ-014 Read data SHALL reflect every write committed at or before the edge entering RESP, including writes to the captured address issued during WAIT.
REQ-015 Address and readM changes during WAIT/RESP SHALL be ignored; readM falling during WAIT SHALL NOT abort the read.
REQ-016 A write SHALL commit mem[address[ADDR_BITS-1:0]] <= data at the rising edge of any cycle with writeM=1, in any FSM state, with zero wait states.
- REQ-016 handshake: writes produce no inputReady.
REQ-017 If readM=1 and writeM=1 together in IDLE, the block SHALL perform the write only and stay in IDLE; the read is accepted on a later IDLE cycle with writeM=0.
REQ-018 In RESP with writeM=1, the block SHALL leave data high-impedance, still pulse inputReady, and still commit the write.
REQ-019 Outside RESP, data SHALL be high-impedance.
REQ-020 Address bits above ADDR_BITS-1 SHALL be ignored, so addresses wrap modulo 2^ADDR_BITS.
REQ-021 A readM still high in the IDLE cycle after RESP SHALL be treated as a new read; requesters deassert readM after inputReady.

Reset
REQ-022 On reset_n=0, the block SHALL immediately set state=IDLE, counter=0, inputReady=0, and data high-impedance.
REQ-023 Reset mid-read SHALL abandon the read: no inputReady follows, and no partial state is retained.
REQ-024 Storage array contents SHALL NOT be cleared by reset.
REQ-025 Writes SHALL be blocked while reset_n=0.

Configuration
REQ-026 With TSC_MEM_ACCESS_COUNT_EN defined, the block SHALL add output ports read_count[15:0] and write_count[15:0].
- REQ-026 counting: read_count increments on each RESP cycle; write_count increments on each committed write.
- REQ-026 reset and wrap: both counters reset to 0 and wrap modulo 2^16.
REQ-027 Without TSC_MEM_ACCESS_COUNT_EN, those ports and counters SHALL be absent, with functional behaviour otherwise identical.

Verification
REQ-028 Scenario, basic read, LATENCY=2:
- Stimulus: preload mem[5]=16'h1234; assert readM with address=5 in cycle 0.
- Response: inputReady=1 and data=16'h1234 in cycle 2 only; data=Z in cycles 0, 1 and 3.
REQ-029 Scenario, write then read:
- Stimulus: writeM=1, address=16'h0107, data=16'hBEEF for one cycle; then read address 7, ADDR_BITS=8.
- Response: data=16'hBEEF on the inputReady cycle (address wrap check).
REQ-030 Scenario, simultaneous request:
- Stimulus: readM=1 and writeM=1 in IDLE, address=3, data=16'h00AA.
- Response: mem[3]=16'h00AA; no inputReady until a cycle with writeM=0 starts a fresh read, which returns 16'h00AA.
REQ-031 Scenario, write during WAIT, LATENCY=4:
- Stimulus: read address 9 with old value 16'h0001; in the second WAIT cycle, write 16'h0002 to address 9.
- Response: inputReady data=16'h0002.
REQ-032 Scenario, reset mid-read:
- Stimulus: reset_n=0 pulse during WAIT.
- Response: inputReady stays 0 afterwards, state=IDLE, and a prior mem[5]=16'h1234 is still readable.
REQ-033 Scenario, TSC_MEM_ACCESS_COUNT_EN defined:
- Stimulus: after 3 reads and 2 writes.
- Response: read_count=3, write_count=2; both return to 0 after reset.
